decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Instruction decode / operand-fetch stage feeding the ALU. Accepts a 32-bit RV32I word over valid/ready,
//  decodes ADD, SUB and ADDI into t_alu, reads rs1/rs2 from an internal register file and presents
//  op/src1/src2/rd to execute through a one-entry output pipeline register. Writeback port updates the regfile.
// PARAMETERS
//  XLEN      32  datapath width (ALU is 32-bit; other values unsupported)
//  NUM_REGS  32  architectural registers; index width REG_AW = $clog2(NUM_REGS)
// PORTS
//  clk_i         in   1       clock; all state on rising edge
//  rst_i         in   1       reset, synchronous, active-high
//  inst_valid_i  in   1       fetch presents inst_i
//  inst_ready_o  out  1       stage can accept inst_i this cycle
//  inst_i        in   32      RV32I instruction word
//  ex_valid_o    out  1       ex_* fields valid for execute
//  ex_ready_i    in   1       execute consumes ex_* this cycle
//  ex_op_o       out  t_alu   ALU operation (drives ALU op_i)
//  ex_src1_o     out  XLEN    operand 1 = rs1 value
//  ex_src2_o     out  XLEN    operand 2 = rs2 value or sign-extended imm
//  ex_rd_o       out  REG_AW  destination register
//  illegal_o     out  1       one-cycle pulse: accepted instruction was not decodable
//  wb_en_i       in   1       writeback strobe
//  wb_rd_i       in   REG_AW  writeback register index
//  wb_data_i     in   XLEN    writeback data
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): ex_valid_o=0, illegal_o=0, ex_op_o=ADD, ex_src1/2_o=0, ex_rd_o=0, all regs=0.
//    Reset mid-operation discards the held entry; no handshake completes in a reset cycle.
//  - Output reg FSM: EMPTY (ex_valid_o=0) / FULL (ex_valid_o=1). inst_ready_o = !ex_valid_o | ex_ready_i
//    (combinational, low during reset). Accept = inst_valid_i & inst_ready_o.
//  - EMPTY: accept legal -> FULL next cycle with decoded fields (latency 1). Accept illegal -> stay EMPTY.
//  - FULL: ex_ready_i=0 -> hold all ex_* stable. ex_ready_i=1 & legal accept -> stay FULL, new fields
//    (back-to-back, 1 instr/cycle). ex_ready_i=1 & no/illegal accept -> EMPTY.
//  - Decode: opc 0110011,f3 000,f7 0000000 -> ADD rs1,rs2; f7 0100000 -> SUB rs1,rs2;
//    opc 0010011,f3 000 -> ADD rs1, sext(inst[31:20]) (ADDI). Anything else illegal: illegal_o=1 for
//    the cycle after accept, entry dropped, no ex_valid_o.
//  - Regfile: combinational read at accept, write at edge when wb_en_i. x0 reads 0; writes to x0 ignored.
//    Arithmetic is plain XLEN wrap; stage performs no arithmetic except sign extension.
//  - Writeback and accept reading the same register in one cycle: see CONFIGURATION.
// CONFIGURATION
//  DECODE_WB_BYPASS_EN defined: read of rs (rs!=0) with wb_en_i & wb_rd_i==rs returns wb_data_i.
//  Not defined: same-cycle read returns pre-write value; regfile updated at edge as usual.
// STRUCTURE
//  riscv_pkg: t_alu (existing ADD/SUB), OPC_OP=7'b0110011, OPC_OP_IMM=7'b0010011, F3_ADD=3'b000,
//   F7_ADD=7'b0000000, F7_SUB=7'b0100000, typedef struct t_id_ex {op, src1, src2, rd}.
//  Sub-module reg_file (2 async read, 1 sync write, sync reset, x0 hardwired 0) instantiated here;
//  decode logic and output register live in decode_stage.
// TESTING
//  1 rst_i 1 cycle -> ex_valid_o=0, inst_ready_o=1; read of any reg after reset returns 0.
//  2 wb x1=5, x2=3; accept ADD x3,x1,x2 (0x002081B3) -> next cycle ex_valid_o=1, op=ADD,
//    src1=5, src2=3, rd=3; then SUB x3,x1,x2 (0x402081B3) -> op=SUB.
//  3 ADDI x4,x1,-1 (0xFFF08213) -> op=ADD, src1=5, src2=0xFFFFFFFF, rd=4.
//  4 hold ex_ready_i=0 3 cycles with inst_valid_i=1 -> inst_ready_o=0, ex_* unchanged;
//    ex_ready_i=1 -> new instr accepted same cycle, FULL continues, no loss/duplication.
//  5 accept 0x00000073 (ECALL) -> illegal_o pulse 1 cycle, ex_valid_o stays 0; wb x0=7 -> x0 reads 0.
//  6 same cycle: wb x1=9 and accept ADD x3,x1,x2 -> src1=9 with DECODE_WB_BYPASS_EN, src1=5 without.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions for the decode/operand-fetch slice.
// Contents: datapath and register-file sizes, ALU operation enum, opcode and
// funct field constants, the decode->execute payload struct, the output
// register state enum and the I-type immediate sign-extension helper.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);

    typedef enum logic [0:0] {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } t_alu;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef struct packed {
        t_alu              op;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [REG_AW-1:0] rd;
    } t_id_ex;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } t_state;

    // Sign-extend the 12-bit I-type immediate (inst[31:20]) to XLEN.
    function automatic logic [XLEN-1:0] sext_i_imm(input logic [11:0] imm12);
        return {{(XLEN-12){imm12[11]}}, imm12};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus bundle around decode_stage: fetch->decode instruction channel,
// decode->execute operand channel, illegal-instruction pulse and the
// register writeback port.
// Modports: slave  = the decode stage itself
//           master = the environment (fetch, execute and writeback side)
interface decode_stage_if;
    import riscv_pkg::*;

    logic              inst_valid_i;
    logic              inst_ready_o;
    logic [31:0]       inst_i;
    logic              ex_valid_o;
    logic              ex_ready_i;
    t_alu              ex_op_o;
    logic [XLEN-1:0]   ex_src1_o;
    logic [XLEN-1:0]   ex_src2_o;
    logic [REG_AW-1:0] ex_rd_o;
    logic              illegal_o;
    logic              wb_en_i;
    logic [REG_AW-1:0] wb_rd_i;
    logic [XLEN-1:0]   wb_data_i;

    modport slave (
        input  inst_valid_i, inst_i, ex_ready_i, wb_en_i, wb_rd_i, wb_data_i,
        output inst_ready_o, ex_valid_o, ex_op_o, ex_src1_o, ex_src2_o, ex_rd_o, illegal_o
    );

    modport master (
        output inst_valid_i, inst_i, ex_ready_i, wb_en_i, wb_rd_i, wb_data_i,
        input  inst_ready_o, ex_valid_o, ex_op_o, ex_src1_o, ex_src2_o, ex_rd_o, illegal_o
    );

endinterface

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one write port
// updated on the rising clock edge, synchronous active-high reset clearing
// every register. x0 always reads zero and ignores writes.
// Optional feature macro: DECODE_WB_BYPASS_EN -- when defined, a read of a
// nonzero register being written in the same cycle returns the write data;
// otherwise it returns the value held before the edge.
// Ports: clk_i, rst_i, rs1_addr/rs1_data, rs2_addr/rs2_data,
//        wb_en/wb_rd/wb_data (write port).
module reg_file
    import riscv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] rs1_addr,
    output logic [XLEN-1:0]   rs1_data,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data
);

    logic [XLEN-1:0] regs_r [NUM_REGS];

    // Write port: clear on reset, otherwise store writeback data (x0 never written).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_en && (wb_rd != {REG_AW{1'b0}})) begin
            regs_r[wb_rd] <= wb_data;
        end
    end

    // Read port helper: x0 is hardwired zero, optional same-cycle writeback forwarding.
    function automatic logic [XLEN-1:0] read_reg(input logic [REG_AW-1:0] addr,
                                                 input logic [XLEN-1:0]   stored);
        logic [XLEN-1:0] val;
        if (addr == {REG_AW{1'b0}}) begin
            val = {XLEN{1'b0}};
        end else begin
`ifdef DECODE_WB_BYPASS_EN
            if (wb_en && (wb_rd == addr)) begin
                val = wb_data;
            end else begin
                val = stored;
            end
`else
            val = stored;
`endif
        end
        return val;
    endfunction

    // Both read ports, combinational.
    always_comb begin
        rs1_data = read_reg(rs1_addr, regs_r[rs1_addr]);
        rs2_data = read_reg(rs2_addr, regs_r[rs2_addr]);
    end

endmodule

// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: accepts RV32I words (ADD, SUB, ADDI), reads
// rs1/rs2 from reg_file and holds op/src1/src2/rd for execute in a one-entry
// output register (EMPTY/FULL). Undecodable accepted words raise illegal_o
// for one cycle and are dropped.
// Optional feature macro: DECODE_WB_BYPASS_EN (forwarding inside reg_file).
// Ports: clk_i (rising edge), rst_i (synchronous, active-high),
//        bus (decode_stage_if.slave: inst/ex handshakes, illegal, writeback).
module decode_stage
    import riscv_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    decode_stage_if.slave bus
);

    t_state          state_r;
    t_id_ex          ex_r;
    logic            illegal_r;

    logic            inst_ready_s;
    logic            accept_s;
    logic            legal_s;
    logic            use_imm_s;
    t_alu            op_s;
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;
    t_id_ex          next_s;

    logic [6:0]      opc_s;
    logic [2:0]      f3_s;
    logic [6:0]      f7_s;

    assign opc_s = bus.inst_i[6:0];
    assign f3_s  = bus.inst_i[14:12];
    assign f7_s  = bus.inst_i[31:25];

    reg_file u_reg_file (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rs1_addr (bus.inst_i[19:15]),
        .rs1_data (rs1_data_s),
        .rs2_addr (bus.inst_i[24:20]),
        .rs2_data (rs2_data_s),
        .wb_en    (bus.wb_en_i),
        .wb_rd    (bus.wb_rd_i),
        .wb_data  (bus.wb_data_i)
    );

    // Ready whenever the output slot is free or being drained; never during reset.
    assign inst_ready_s = !rst_i && ((state_r == ST_EMPTY) || bus.ex_ready_i);
    assign accept_s     = bus.inst_valid_i && inst_ready_s;

    // Instruction decode; ADDI reuses the ADD operation with the immediate as src2.
    always_comb begin
        legal_s   = 1'b0;
        use_imm_s = 1'b0;
        op_s      = ALU_ADD;
        case (opc_s)
            OPC_OP: begin
                if ((f3_s == F3_ADD) && (f7_s == F7_ADD)) begin
                    legal_s = 1'b1;
                end else if ((f3_s == F3_ADD) && (f7_s == F7_SUB)) begin
                    legal_s = 1'b1;
                    op_s    = ALU_SUB;
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                if (f3_s == F3_ADD) begin
                    legal_s   = 1'b1;
                    use_imm_s = 1'b1;
                end else begin
                    legal_s = 1'b0;
                end
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // Assemble the candidate payload for the output register.
    always_comb begin
        next_s.op   = op_s;
        next_s.src1 = rs1_data_s;
        next_s.rd   = bus.inst_i[11:7];
        if (use_imm_s) begin
            next_s.src2 = sext_i_imm(bus.inst_i[31:20]);
        end else begin
            next_s.src2 = rs2_data_s;
        end
    end

    // Output register FSM: EMPTY/FULL occupancy, payload and illegal pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_EMPTY;
            illegal_r <= 1'b0;
            ex_r      <= '{op: ALU_ADD, src1: {XLEN{1'b0}}, src2: {XLEN{1'b0}}, rd: {REG_AW{1'b0}}};
        end else begin
            illegal_r <= accept_s && !legal_s;
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s && legal_s) begin
                        state_r <= ST_FULL;
                        ex_r    <= next_s;
                    end
                end
                ST_FULL: begin
                    // A stalled entry keeps its payload; a drained one is either
                    // replaced in the same cycle or the slot empties.
                    if (bus.ex_ready_i) begin
                        if (accept_s && legal_s) begin
                            ex_r <= next_s;
                        end else begin
                            state_r <= ST_EMPTY;
                        end
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    assign bus.inst_ready_o = inst_ready_s;
    assign bus.ex_valid_o   = (state_r == ST_FULL);
    assign bus.ex_op_o      = ex_r.op;
    assign bus.ex_src1_o    = ex_r.src1;
    assign bus.ex_src2_o    = ex_r.src2;
    assign bus.ex_rd_o      = ex_r.rd;
    assign bus.illegal_o    = illegal_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point, so registered outputs
// reflect the edge just taken and combinational ready reflects the new inputs.
module tb_decode_stage;
    import riscv_pkg::*;

    localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_SUB   = 32'h402081B3; // sub  x3,x1,x2
    localparam logic [31:0] I_ADDI  = 32'hFFF08213; // addi x4,x1,-1
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_MUL   = 32'h022081B3; // mul  x3,x1,x2 (not supported)
    localparam logic [31:0] I_ADD0  = 32'h002001B3; // add  x3,x0,x2

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    decode_stage_if bus ();

    decode_stage dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_valid_i = 1'b0;
        bus.inst_i       = 32'h0000_0013;
        bus.ex_ready_i   = 1'b1;
        bus.wb_en_i      = 1'b0;
        bus.wb_rd_i      = 5'd0;
        bus.wb_data_i    = 32'h0;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_en_i   = 1'b1;
        bus.wb_rd_i   = rd;
        bus.wb_data_i = data;
        cyc();
        bus.wb_en_i   = 1'b0;
    endtask

    task automatic check_ex(input string name, input logic valid, input t_alu op,
                            input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] rd);
        checks++;
        if (bus.ex_valid_o !== valid || bus.ex_op_o !== op || bus.ex_src1_o !== s1 ||
            bus.ex_src2_o !== s2 || bus.ex_rd_o !== rd) begin
            failures++;
            $display("FAIL %s: got v=%b op=%0d s1=%h s2=%h rd=%0d, want v=%b op=%0d s1=%h s2=%h rd=%0d",
                     name, bus.ex_valid_o, bus.ex_op_o, bus.ex_src1_o, bus.ex_src2_o, bus.ex_rd_o,
                     valid, op, s1, s2, rd);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        cyc();
        check_ex("reset_ex", 1'b0, ALU_ADD, 32'h0, 32'h0, 5'd0);
        check_bit("reset_illegal", bus.illegal_o, 1'b0);
        check_bit("reset_ready_low", bus.inst_ready_o, 1'b0);
        rst_i = 1'b0;
        #1;
        check_bit("post_reset_ready", bus.inst_ready_o, 1'b1);
        // Reading x1/x2 straight after reset must give zero.
        bus.inst_valid_i = 1'b1;
        bus.inst_i       = I_ADD;
        cyc();
        bus.inst_valid_i = 1'b0;
        check_ex("reset_regs_zero", 1'b1, ALU_ADD, 32'h0, 32'h0, 5'd3);
        cyc();
        check_bit("reset_drain", bus.ex_valid_o, 1'b0);
    endtask

    task automatic test_add_sub();
        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd3);
        bus.inst_valid_i = 1'b1;
        bus.inst_i       = I_ADD;
        cyc();
        check_ex("add", 1'b1, ALU_ADD, 32'd5, 32'd3, 5'd3);
        bus.inst_i = I_SUB;
        cyc();
        check_ex("sub", 1'b1, ALU_SUB, 32'd5, 32'd3, 5'd3);
        bus.inst_valid_i = 1'b0;
        cyc();
        check_bit("add_sub_drain", bus.ex_valid_o, 1'b0);
    endtask

    task automatic test_addi();
        bus.inst_valid_i = 1'b1;
        bus.inst_i       = I_ADDI;
        cyc();
        bus.inst_valid_i = 1'b0;
        check_ex("addi", 1'b1, ALU_ADD, 32'd5, 32'hFFFF_FFFF, 5'd4);
        cyc();
        check_bit("addi_drain", bus.ex_valid_o, 1'b0);
    endtask

    task automatic test_back_to_back();
        bus.inst_valid_i = 1'b1;
        bus.inst_i       = I_ADD;
        bus.ex_ready_i   = 1'b1;
        cyc();
        check_ex("bp_first", 1'b1, ALU_ADD, 32'd5, 32'd3, 5'd3);
        bus.inst_i     = I_SUB;
        bus.ex_ready_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_bit("bp_ready_low", bus.inst_ready_o, 1'b0);
            cyc();
            check_ex("bp_hold", 1'b1, ALU_ADD, 32'd5, 32'd3, 5'd3);
        end
        bus.ex_ready_i = 1'b1;
        #1;
        check_bit("bp_ready_release", bus.inst_ready_o, 1'b1);
        cyc();
        bus.inst_valid_i = 1'b0;
        check_ex("bp_next", 1'b1, ALU_SUB, 32'd5, 32'd3, 5'd3);
        cyc();
        check_bit("bp_drain", bus.ex_valid_o, 1'b0);
    endtask

    task automatic test_illegal();
        bus.inst_valid_i = 1'b1;
        bus.inst_i       = I_ECALL;
        cyc();
        bus.inst_valid_i = 1'b0;
        check_bit("ecall_pulse", bus.illegal_o, 1'b1);
        check_bit("ecall_no_valid", bus.ex_valid_o, 1'b0);
        cyc();
        check_bit("ecall_pulse_end", bus.illegal_o, 1'b0);
        // Illegal word arriving while FULL and draining empties the slot.
        bus.inst_valid_i = 1'b1;
        bus.inst_i       = I_ADD;
        cyc();
        bus.inst_i = I_MUL;
        cyc();
        bus.inst_valid_i = 1'b0;
        check_bit("mul_pulse", bus.illegal_o, 1'b1);
        check_bit("mul_empties", bus.ex_valid_o, 1'b0);
        cyc();
        write_reg(5'd0, 32'd7);
        bus.inst_valid_i = 1'b1;
        bus.inst_i       = I_ADD0;
        cyc();
        bus.inst_valid_i = 1'b0;
        check_ex("x0_reads_zero", 1'b1, ALU_ADD, 32'd0, 32'd3, 5'd3);
        cyc();
    endtask

    task automatic test_wb_same_cycle();
        logic [31:0] exp_src1;
`ifdef DECODE_WB_BYPASS_EN
        exp_src1 = 32'd9;
`else
        exp_src1 = 32'd5;
`endif
        bus.wb_en_i      = 1'b1;
        bus.wb_rd_i      = 5'd1;
        bus.wb_data_i    = 32'd9;
        bus.inst_valid_i = 1'b1;
        bus.inst_i       = I_ADD;
        cyc();
        bus.wb_en_i = 1'b0;
        check_ex("wb_same_cycle", 1'b1, ALU_ADD, exp_src1, 32'd3, 5'd3);
        cyc();
        bus.inst_valid_i = 1'b0;
        check_ex("wb_committed", 1'b1, ALU_ADD, 32'd9, 32'd3, 5'd3);
        cyc();
    endtask

    task automatic test_reset_mid();
        bus.inst_valid_i = 1'b1;
        bus.inst_i       = I_SUB;
        cyc();
        bus.ex_ready_i = 1'b0;
        rst_i          = 1'b1;
        cyc();
        check_bit("midrst_valid", bus.ex_valid_o, 1'b0);
        rst_i          = 1'b0;
        bus.ex_ready_i = 1'b1;
        bus.inst_i     = I_ADD;
        cyc();
        bus.inst_valid_i = 1'b0;
        check_ex("midrst_regs_clear", 1'b1, ALU_ADD, 32'd0, 32'd0, 5'd3);
        cyc();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_wb_same_cycle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
